// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer: controller states,
// count direction and the default count width.
package count_seq_pkg;

    localparam int CNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_DOWN = 1'b0,
        MODE_UP   = 1'b1
    } mode_t;

endpackage

// File: rtl/count_step_dp.sv
// Loadable up/down count register. Load wins over step; wrap flags a step
// that crosses the all-ones/zero boundary in the current direction.
module count_step_dp
    import count_seq_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  mode_t            mode,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    assign wrap = en && (((mode == MODE_UP)   && (cnt == ALL_ONES)) ||
                         ((mode == MODE_DOWN) && (cnt == '0)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= (mode == MODE_UP) ? cnt + ONE : cnt - ONE;
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Command-driven counter: accepts {mode, start, len}, steps the count len
// times (pausable, abortable) and pulses done on completion.
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_len,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] cnt_out,
    output logic             busy,
    output logic             done,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state;
    mode_t            mode_q;
    logic [WIDTH-1:0] steps_left;
    logic             done_q;
    logic             wrapped_q;
    logic             accept;
    logic             step;
    logic             wrap_ind;

    // Abort blocks acceptance and overrides both pause and step completion.
    assign accept = cmd_valid && (state == IDLE) && !abort;
    assign step   = (state == RUN) && !abort && !pause;

    count_step_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (cmd_start),
        .en       (step),
        .mode     (mode_q),
        .cnt      (cnt_out),
        .wrap     (wrap_ind)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mode_q     <= MODE_UP;
            steps_left <= '0;
            done_q     <= 1'b0;
            wrapped_q  <= 1'b0;
        end else begin
            // NOTE: default-low here makes done a single-cycle pulse without
            // having to clear it on every other branch.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mode_q     <= mode_t'(cmd_mode);
                        steps_left <= cmd_len;
                        wrapped_q  <= 1'b0;
                        if (cmd_len == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (!pause) begin
                        steps_left <= steps_left - ONE;
                        if (wrap_ind) begin
                            wrapped_q <= 1'b1;
                        end
                        if (steps_left == ONE) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign wrapped   = wrapped_q;

endmodule
